// File: rtl/sd_init_ctrl.sv
// SD card identification/configuration sequencer: walks CMD0..ACMD6 through the
// command engine, captures the RCA and reports ready or an abort reason.
module sd_init_ctrl #(
  parameter int MAX_POLLS    = 1000,
  parameter int RESP_TIMEOUT = 4096
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_idx,
  output logic [31:0] ocmd_arg,
  output logic        oresp_exp,
  input  logic        icmd_done,
  input  logic [31:0] iresp,
  input  logic        icrc_err,
  output logic        obusy,
  output logic        oready,
  output logic        oerror,
  output logic [2:0]  oerr_code,
  output logic [15:0] orca,
  output logic [2:0]  dbg_state
);

  // Command handshake: ocmd_start is a one-cycle request, and ocmd_idx/ocmd_arg/
  // oresp_exp hold steady until the matching one-cycle icmd_done, which carries
  // iresp/icrc_err in that same cycle. Only one command is ever outstanding.

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);

  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_ECHO    = 3'd3;
  localparam logic [2:0] ERR_POLLS   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE, S_ERR
  } state_t;

  typedef enum logic [3:0] {
    ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2,
    ST_CMD3, ST_CMD7, ST_CMD55_RCA, ST_ACMD6
  } step_t;

  state_t         state, state_nxt;
  step_t          step, step_nxt;
  logic [PW-1:0]  poll_cnt, poll_nxt;
  logic [TW-1:0]  tcnt;
  logic [15:0]    rca_q, rca_nxt;
  logic [2:0]     code_q, code_nxt;
  logic [31:0]    resp_q;
  logic           crc_q;
  logic           unused_resp_bits;

  assign unused_resp_bits = ^resp_q[15:12];

  always_ff @(posedge iclk) begin
    if (irst) begin
      state    <= S_IDLE;
      step     <= ST_CMD0;
      poll_cnt <= '0;
      rca_q    <= '0;
      code_q   <= '0;
      tcnt     <= '0;
      resp_q   <= '0;
      crc_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      poll_cnt <= poll_nxt;
      rca_q    <= rca_nxt;
      code_q   <= code_nxt;
      if (state == S_ISSUE) begin
        tcnt <= '0;
      end else if (state == S_WAIT) begin
        tcnt <= tcnt + TW'(1);
      end
      if (state == S_WAIT && icmd_done) begin
        resp_q <= iresp;
        crc_q  <= icrc_err;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    poll_nxt  = poll_cnt;
    rca_nxt   = rca_q;
    code_nxt  = code_q;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (istart) begin
          state_nxt = S_ISSUE;
          step_nxt  = ST_CMD0;
          poll_nxt  = '0;
          rca_nxt   = '0;
          code_nxt  = '0;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // A completion arriving on the last timeout cycle still counts.
        if (icmd_done) begin
          state_nxt = S_EVAL;
        end else if (tcnt == TO_LAST) begin
          state_nxt = S_ERR;
          code_nxt  = ERR_TIMEOUT;
        end
      end
      S_EVAL: begin
        // CMD0 has no response and R3 (ACMD41) has no valid CRC.
        if (crc_q && step != ST_CMD0 && step != ST_ACMD41) begin
          state_nxt = S_ERR;
          code_nxt  = ERR_CRC;
        end else begin
          state_nxt = S_ISSUE;
          case (step)
            ST_CMD8: begin
              if (resp_q[11:0] != 12'h1AA) begin
                state_nxt = S_ERR;
                code_nxt  = ERR_ECHO;
              end else begin
                step_nxt = ST_CMD55;
              end
            end
            ST_ACMD41: begin
              if (resp_q[31]) begin
                step_nxt = ST_CMD2;
              end else if (poll_cnt == POLL_LAST) begin
                state_nxt = S_ERR;
                code_nxt  = ERR_POLLS;
              end else begin
                poll_nxt = poll_cnt + PW'(1);
                step_nxt = ST_CMD55;
              end
            end
            ST_CMD3: begin
              rca_nxt  = resp_q[31:16];
              step_nxt = ST_CMD7;
            end
            ST_ACMD6: state_nxt = S_DONE;
            default:  step_nxt  = step_t'(step + 4'd1);
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ocmd_idx  = '0;
    ocmd_arg  = '0;
    oresp_exp = 1'b0;
    if (state == S_ISSUE || state == S_WAIT) begin
      oresp_exp = 1'b1;
      case (step)
        ST_CMD0:      oresp_exp = 1'b0;
        ST_CMD8:      begin ocmd_idx = 6'd8;  ocmd_arg = 32'h0000_01AA; end
        ST_CMD55:     ocmd_idx = 6'd55;
        ST_ACMD41:    begin ocmd_idx = 6'd41; ocmd_arg = 32'h40FF_8000; end
        ST_CMD2:      ocmd_idx = 6'd2;
        ST_CMD3:      ocmd_idx = 6'd3;
        ST_CMD7:      begin ocmd_idx = 6'd7;  ocmd_arg = {rca_q, 16'h0}; end
        ST_CMD55_RCA: begin ocmd_idx = 6'd55; ocmd_arg = {rca_q, 16'h0}; end
        ST_ACMD6:     begin ocmd_idx = 6'd6;  ocmd_arg = 32'h0000_0002; end
        default:      oresp_exp = 1'b0;
      endcase
    end
  end

  assign ocmd_start = (state == S_ISSUE);
  assign obusy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_EVAL);
  assign oready     = (state == S_DONE);
  assign oerror     = (state == S_ERR);
  assign oerr_code  = code_q;
  assign orca       = rca_q;
  assign dbg_state  = state;

endmodule
